// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with character FIFO
//
// Queues single-cycle character strobes in a circular FIFO and shifts each
// character out LSB-first as start bit, 8 data bits and stop bit, each bit
// held BAUDDIV clock cycles. Frames run gapless while the FIFO holds data.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   synchronous active-low reset
//   I_STB  in   character valid strobe, one cycle per character
//   I_DAT  in   [7:0] character, valid with I_STB
//   O_TXD  out  registered serial output, idle high
//   O_BUSY out  registered: FIFO non-empty or frame in progress
//   O_OVF  out  sticky: a character was dropped on a full FIFO
module uart_tx_fifo #(
  parameter int BAUDDIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       I_STB,
  input  logic [7:0] I_DAT,
  output logic       O_TXD,
  output logic       O_BUSY,
  output logic       O_OVF
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUDDIV);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] RELOAD_C = BW'(BAUDDIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic          txd_nxt;
  logic          busy_nxt;

  logic          pop;
  logic          push;
  logic          drop;
  logic          fifo_nempty;
  logic          baud_zero;

  assign fifo_nempty = (count != '0);
  assign baud_zero   = (baud == '0);

  // A full FIFO still accepts a character when the FSM pops on the same edge.
  assign push = I_STB && ((count != DEPTH_C) || pop);
  assign drop = I_STB && !push;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    shift_nxt = shift;
    idx_nxt   = idx;
    txd_nxt   = O_TXD;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (fifo_nempty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          txd_nxt   = 1'b0;
          baud_nxt  = RELOAD_C;
          state_nxt = START;
        end
      end
      START: begin
        baud_nxt = baud - BW'(1);
        if (baud_zero) begin
          txd_nxt   = shift[0];
          baud_nxt  = RELOAD_C;
          idx_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        baud_nxt = baud - BW'(1);
        if (baud_zero) begin
          baud_nxt = RELOAD_C;
          if (idx != 3'd7) begin
            shift_nxt = {1'b0, shift[7:1]};
            txd_nxt   = shift[1];
            idx_nxt   = idx + 3'd1;
          end else begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        baud_nxt = baud - BW'(1);
        if (baud_zero) begin
          if (fifo_nempty) begin
            // Next start bit begins on the edge that ends this stop bit.
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            txd_nxt   = 1'b0;
            baud_nxt  = RELOAD_C;
            state_nxt = START;
          end else begin
            baud_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      baud   <= '0;
      shift  <= '0;
      idx    <= '0;
      O_TXD  <= 1'b1;
      O_BUSY <= 1'b0;
      O_OVF  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      baud   <= baud_nxt;
      shift  <= shift_nxt;
      idx    <= idx_nxt;
      O_TXD  <= txd_nxt;
      O_BUSY <= busy_nxt;
      count  <= count_nxt;
      if (drop) begin
        O_OVF <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      mem[wr_ptr] <= I_DAT;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST_N;
  logic       I_STB;
  logic [7:0] I_DAT;
  logic       O_TXD;
  logic       O_BUSY;
  logic       O_OVF;

  int n_checks;
  int n_fail;

  logic [7:0] rx_d [16];
  logic       rx_ok [16];
  int         rx_w [16];

  uart_tx_fifo #(
    .BAUDDIV   (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .I_STB (I_STB),
    .I_DAT (I_DAT),
    .O_TXD (O_TXD),
    .O_BUSY(O_BUSY),
    .O_OVF (O_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    I_STB = 1'b0;
    I_DAT = 8'h00;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Line monitor: called on a negedge; waits up to budget negedges for a
  // start bit, then samples every cycle of all 10 bits. Returns on the last
  // negedge of the stop bit.
  task automatic rx_frame(input int budget, output logic [7:0] d,
                          output logic ok, output int waited);
    logic       v;
    logic [9:0] bits;
    logic       stable;
    waited = 0;
    while (O_TXD !== 1'b0 && waited < budget) begin
      @(negedge CLK);
      waited++;
    end
    stable = (O_TXD === 1'b0);
    for (int b = 0; b < 10; b++) begin
      v = O_TXD;
      bits[b] = v;
      for (int j = 1; j < BAUD; j++) begin
        @(negedge CLK);
        if (O_TXD !== v) stable = 1'b0;
      end
      if (b < 9) @(negedge CLK);
    end
    d = bits[8:1];
    ok = stable && (bits[0] === 1'b0) && (bits[9] === 1'b1);
  endtask

  task automatic rx_frames(input int n, input int first_budget, input int rest_budget);
    logic [7:0] d;
    logic       ok;
    int         w;
    for (int i = 0; i < n; i++) begin
      rx_frame((i == 0) ? first_budget : rest_budget, d, ok, w);
      rx_d[i] = d;
      rx_ok[i] = ok;
      rx_w[i] = w;
      if (i < n - 1) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (O_TXD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", O_TXD); end
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", O_BUSY); end
    n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", O_OVF); end
  endtask

  task automatic test_single();
    do_reset();
    fork
      begin
        I_STB = 1'b1;
        I_DAT = 8'h55;
        @(negedge CLK);
        I_STB = 1'b0;
        n_checks++; if (O_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", O_BUSY); end
        n_checks++; if (O_TXD !== 1'b1) begin n_fail++; $display("FAIL single_txd_e0: got %b expected 1", O_TXD); end
      end
      rx_frames(1, 6, 0);
    join
    n_checks++; if (rx_w[0] !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", rx_w[0]); end
    n_checks++; if (rx_ok[0] !== 1'b1) begin n_fail++; $display("FAIL single_framing: got %b expected 1", rx_ok[0]); end
    n_checks++; if (rx_d[0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", rx_d[0]); end
    n_checks++; if (O_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop: got %b expected 1", O_BUSY); end
    @(negedge CLK);
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", O_BUSY); end
    n_checks++; if (O_TXD !== 1'b1) begin n_fail++; $display("FAIL single_txd_idle: got %b expected 1", O_TXD); end
    n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b expected 0", O_OVF); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h0D; exp_d[1] = 8'h0A; exp_d[2] = 8'h41;
    do_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          I_STB = 1'b1;
          I_DAT = exp_d[i];
          @(negedge CLK);
        end
        I_STB = 1'b0;
      end
      rx_frames(3, 6, 0);
    join
    n_checks++; if (rx_w[0] !== 2) begin n_fail++; $display("FAIL burst_latency: got %0d expected 2", rx_w[0]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rx_ok[i] !== 1'b1) begin n_fail++; $display("FAIL burst_framing[%0d]: got %b expected 1", i, rx_ok[i]); end
      n_checks++; if (rx_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", i, rx_d[i], exp_d[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (rx_w[i] !== 0) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d expected 0", i, rx_w[i]); end
    end
    @(negedge CLK);
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b expected 0", O_BUSY); end
    n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL burst_ovf: got %b expected 0", O_OVF); end
  endtask

  task automatic test_overflow();
    logic low_seen;
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          I_STB = 1'b1;
          I_DAT = 8'h30 + 8'(i);
          if (i == 5) begin
            n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop: got %b expected 0", O_OVF); end
          end
          @(negedge CLK);
        end
        I_STB = 1'b0;
        n_checks++; if (O_OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_rise: got %b expected 1", O_OVF); end
      end
      rx_frames(5, 6, 0);
    join
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rx_ok[i] !== 1'b1) begin n_fail++; $display("FAIL ovf_framing[%0d]: got %b expected 1", i, rx_ok[i]); end
      n_checks++; if (rx_d[i] !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, rx_d[i], 8'h30 + 8'(i)); end
    end
    low_seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (O_TXD !== 1'b1) low_seen = 1'b1;
    end
    n_checks++; if (low_seen !== 1'b0) begin n_fail++; $display("FAIL ovf_no_sixth: got %b expected 0", low_seen); end
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end: got %b expected 0", O_BUSY); end
    n_checks++; if (O_OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", O_OVF); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    fork
      begin
        // Five strobes: first is popped immediately, four fill the FIFO.
        for (int i = 0; i < 5; i++) begin
          I_STB = 1'b1;
          I_DAT = 8'hA0 + 8'(i);
          @(negedge CLK);
        end
        I_STB = 1'b0;
        // First stop bit ends (and pops) on the 41st edge after the first strobe.
        repeat (36) @(negedge CLK);
        I_STB = 1'b1;
        I_DAT = 8'hA5;
        @(negedge CLK);
        I_STB = 1'b0;
        n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf: got %b expected 0", O_OVF); end
      end
      rx_frames(6, 6, 0);
    join
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (rx_ok[i] !== 1'b1) begin n_fail++; $display("FAIL full_framing[%0d]: got %b expected 1", i, rx_ok[i]); end
      n_checks++; if (rx_d[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, rx_d[i], 8'hA0 + 8'(i)); end
    end
    @(negedge CLK);
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", O_BUSY); end
  endtask

  task automatic test_reset_mid();
    logic low_seen;
    logic [7:0] q [3];
    q[0] = 8'h00; q[1] = 8'h11; q[2] = 8'h22;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      I_STB = 1'b1;
      I_DAT = q[i];
      @(negedge CLK);
    end
    I_STB = 1'b0;
    repeat (15) @(negedge CLK);
    n_checks++; if (O_TXD !== 1'b0) begin n_fail++; $display("FAIL mid_bit3_level: got %b expected 0", O_TXD); end
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    n_checks++; if (O_TXD !== 1'b1) begin n_fail++; $display("FAIL mid_txd_after_rst: got %b expected 1", O_TXD); end
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after_rst: got %b expected 0", O_BUSY); end
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (O_TXD !== 1'b1 || O_BUSY !== 1'b0) low_seen = 1'b1;
    end
    n_checks++; if (low_seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_frames: got %b expected 0", low_seen); end
    fork
      begin
        I_STB = 1'b1;
        I_DAT = 8'h5A;
        @(negedge CLK);
        I_STB = 1'b0;
      end
      rx_frames(1, 6, 0);
    join
    n_checks++; if (rx_ok[0] !== 1'b1) begin n_fail++; $display("FAIL mid_new_framing: got %b expected 1", rx_ok[0]); end
    n_checks++; if (rx_d[0] !== 8'h5A) begin n_fail++; $display("FAIL mid_new_data: got %h expected 5a", rx_d[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          I_STB = 1'b1;
          I_DAT = 8'(i * 27 + 3);
          @(negedge CLK);
          I_STB = 1'b0;
          repeat (10 * BAUD - 1) @(negedge CLK);
        end
      end
      rx_frames(10, 6, 10 * BAUD);
    join
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rx_ok[i] !== 1'b1) begin n_fail++; $display("FAIL wrap_framing[%0d]: got %b expected 1", i, rx_ok[i]); end
      n_checks++; if (rx_d[i] !== 8'(i * 27 + 3)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rx_d[i], 8'(i * 27 + 3)); end
    end
    @(negedge CLK);
    n_checks++; if (O_OVF !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", O_OVF); end
    n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_end: got %b expected 0", O_BUSY); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    RST_N = 1'b0;
    I_STB = 1'b0;
    I_DAT = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
